// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Brief    : Shared types and constants for the reorder buffer slice.
// Revision : 1.0 - initial release
// ============================================================================
package rob_pkg;

    // Default widths, expressed as MSB positions
    localparam int PKG_WIDTH = 31;
    localparam int PKG_REG   = 4;
    localparam int PKG_ROB   = 2;
    localparam int PKG_INDEX = 7;

    localparam int DEPTH = 2 ** (PKG_ROB + 1);

    // Bit positions inside the 4-bit instruction info field
    localparam int COMMIT_REGW = 3;
    localparam int COMMIT_MEMW = 2;
    localparam int COMMIT_BR   = 1;
    localparam int COMMIT_JALR = 0;

    // One reorder buffer slot
    typedef struct packed {
        logic [3:0]         info;
        logic [PKG_REG:0]   dest;
        logic [PKG_WIDTH:0] result;
        logic [PKG_WIDTH:0] target;
        logic [PKG_WIDTH:0] pc;
        logic [PKG_INDEX:0] phtIdx;
        logic [PKG_WIDTH:0] regStatus;
        logic               ready;
        logic               mispredict;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_pointer.sv
`default_nettype none
// ============================================================================
// Module   : rob_pointer
// Brief    : Head/tail pointers with an extra wrap bit, occupancy and
//            full/empty flags for the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
module rob_pointer #(
    parameter int ROB = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc_tail,
    input  logic         inc_head,
    output logic [ROB:0] head_idx,
    output logic [ROB:0] tail_idx,
    output logic [ROB+1:0] count,
    output logic         full,
    output logic         empty
);

    logic [ROB+1:0] r_head;
    logic [ROB+1:0] r_tail;

    // Advance pointers on allocate/commit; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (inc_head) begin
                r_head <= r_head + 1'b1;
            end
            if (inc_tail) begin
                r_tail <= r_tail + 1'b1;
            end
        end
    end

    assign head_idx = r_head[ROB:0];
    assign tail_idx = r_tail[ROB:0];
    assign count    = r_tail - r_head;
    assign empty    = (r_tail == r_head);
    // Same slot index but different lap means every slot is occupied
    assign full     = (r_tail[ROB:0] == r_head[ROB:0]) && (r_tail[ROB+1] != r_head[ROB+1]);

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular in-order reorder buffer. Allocates at tail, captures
//            CDB results out of order, retires in order at head and raises a
//            pipeline flush when a mispredicted branch/JALR retires.
//            Entry field widths come from rob_pkg and must match the
//            parameters below.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int WIDTH = PKG_WIDTH,
    parameter int REG   = PKG_REG,
    parameter int ROB   = PKG_ROB,
    parameter int INDEX = PKG_INDEX
) (
    input  logic             clk,
    input  logic             globalReset,
    input  logic             allocValid,
    input  logic [3:0]       allocInfo,
    input  logic [REG:0]     allocDest,
    input  logic [INDEX:0]   allocPHTIndex,
    input  logic [WIDTH:0]   allocRegStatus,
    input  logic [WIDTH:0]   allocPC,
    input  logic             cdbValid,
    input  logic [ROB:0]     cdbROB,
    input  logic [WIDTH:0]   cdbResult,
    input  logic             cdbMispredict,
    input  logic [WIDTH:0]   cdbTarget,
    output logic [ROB:0]     robAllocation,
    output logic             fullRob,
    output logic             validCommit,
    output logic [ROB:0]     commitROB,
    output logic [REG:0]     destCommit,
    output logic [WIDTH:0]   result,
    output logic [3:0]       commitInfo,
    output logic [WIDTH:0]   statusSnap,
    output logic [INDEX:0]   PHTIndex,
    output logic [WIDTH:0]   redirectPC,
    output logic [1:0]       controlFlow
);

    localparam int NUM_ENTRIES = 2 ** (ROB + 1);

    rob_entry_t     r_entries [NUM_ENTRIES];

    logic           r_valid_commit;
    logic [ROB:0]   r_commit_rob;
    logic [REG:0]   r_dest_commit;
    logic [WIDTH:0] r_result;
    logic [3:0]     r_commit_info;
    logic [WIDTH:0] r_status_snap;
    logic [INDEX:0] r_pht_index;
    logic [WIDTH:0] r_redirect_pc;
    logic [1:0]     r_control_flow;

    logic [ROB:0]   w_head_idx;
    logic [ROB:0]   w_tail_idx;
    logic [ROB+1:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_flush;
    logic           w_alloc;
    logic           w_commit;
    logic [ROB:0]   w_cdb_offset;
    logic           w_cdb_hit;

    // A flush is in progress for exactly the cycle controlFlow[0] is high
    assign w_flush      = r_control_flow[0];
    assign w_alloc      = allocValid & ~w_full & ~w_flush;
    assign w_commit     = ~w_empty & r_entries[w_head_idx].ready & ~w_flush;
    // A tag is live only if its distance from head is below the occupancy
    assign w_cdb_offset = cdbROB - w_head_idx;
    assign w_cdb_hit    = cdbValid & ~w_flush & ({1'b0, w_cdb_offset} < w_count);

    rob_pointer #(
        .ROB      (ROB)
    ) u_pointer (
        .clk      (clk),
        .rst      (globalReset),
        .clear    (w_flush),
        .inc_tail (w_alloc),
        .inc_head (w_commit),
        .head_idx (w_head_idx),
        .tail_idx (w_tail_idx),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    // Entry storage: allocate at tail, capture CDB writes, drop ready on retire
    always_ff @(posedge clk) begin
        if (globalReset || w_flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i].ready      <= 1'b0;
                r_entries[i].mispredict <= 1'b0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[w_tail_idx].info       <= allocInfo;
                r_entries[w_tail_idx].dest       <= allocDest;
                r_entries[w_tail_idx].pc         <= allocPC;
                r_entries[w_tail_idx].phtIdx     <= allocPHTIndex;
                r_entries[w_tail_idx].regStatus  <= allocRegStatus;
                r_entries[w_tail_idx].result     <= '0;
                r_entries[w_tail_idx].target     <= '0;
                r_entries[w_tail_idx].ready      <= 1'b0;
                r_entries[w_tail_idx].mispredict <= 1'b0;
            end
            if (w_cdb_hit) begin
                r_entries[cdbROB].result     <= cdbResult;
                r_entries[cdbROB].target     <= cdbTarget;
                r_entries[cdbROB].mispredict <= cdbMispredict;
                r_entries[cdbROB].ready      <= 1'b1;
            end
            if (w_commit) begin
                r_entries[w_head_idx].ready <= 1'b0;
            end
        end
    end

    // Registered commit bus; payload holds between commits, strobes pulse
    always_ff @(posedge clk) begin
        if (globalReset) begin
            r_valid_commit <= 1'b0;
            r_commit_rob   <= '0;
            r_dest_commit  <= '0;
            r_result       <= '0;
            r_commit_info  <= '0;
            r_status_snap  <= '0;
            r_pht_index    <= '0;
            r_redirect_pc  <= '0;
            r_control_flow <= 2'b00;
        end else begin
            r_valid_commit <= w_commit;
            r_control_flow <= 2'b00;
            if (w_commit) begin
                r_commit_rob   <= w_head_idx;
                r_dest_commit  <= r_entries[w_head_idx].dest;
                r_result       <= r_entries[w_head_idx].result;
                r_commit_info  <= r_entries[w_head_idx].info;
                r_status_snap  <= r_entries[w_head_idx].regStatus;
                r_pht_index    <= r_entries[w_head_idx].phtIdx;
                r_control_flow <= {r_entries[w_head_idx].info[COMMIT_BR] |
                                   r_entries[w_head_idx].info[COMMIT_JALR],
                                   r_entries[w_head_idx].mispredict};
                if (r_entries[w_head_idx].mispredict) begin
                    r_redirect_pc <= r_entries[w_head_idx].target;
                end
            end
        end
    end

    assign robAllocation = w_tail_idx;
    assign fullRob       = w_full;
    assign validCommit   = r_valid_commit;
    assign commitROB     = r_commit_rob;
    assign destCommit    = r_dest_commit;
    assign result        = r_result;
    assign commitInfo    = r_commit_info;
    assign statusSnap    = r_status_snap;
    assign PHTIndex      = r_pht_index;
    assign redirectPC    = r_redirect_pc;
    assign controlFlow   = r_control_flow;

endmodule
`default_nettype wire
